// File: rtl/cpu_pkg.sv
// Shared definitions for the register file: default widths and the
// soft-clear FSM state encoding.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Soft-clear sequencer: walks every entry once, emitting a zeroing write
// per cycle, then pulses clr_done for one cycle before returning to idle.
module regfile_clear_fsm
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  // Last entry index; the terminal compare ends the sweep rather than wrap.
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and sweep counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    clr_we   = 1'b0;
    unique case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_CLEAR;
          cnt_d   = '0;
        end
      end
      CLR_CLEAR: begin
        clr_busy = 1'b1;
        clr_we   = 1'b1;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = CLR_DONE;
        end
      end
      CLR_DONE: begin
        clr_busy = 1'b1;
        clr_done = 1'b1;
        state_d  = CLR_IDLE;
      end
      default: begin
        state_d = CLR_IDLE;
      end
    endcase
  end

  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with N combinational read ports, one write port, optional
// write-to-read bypass, a per-entry pending bit for hazard detection and a
// sequential soft-clear engine. Writes/issues are dropped while clearing.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              idle, wr_ok, iss_ok;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clr (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign idle   = !clr_busy;
  assign wr_ok  = idle && wr_en  && !(ZERO_REG && (wr_addr  == '0));
  assign iss_ok = idle && iss_en && !(ZERO_REG && (iss_addr == '0));

  // Next array/pending contents; issue is applied last so that a same-cycle
  // write and issue to one entry leaves it pending (newer producer wins).
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (clr_we) begin
      mem_d[clr_addr]  = '0;
      pend_d[clr_addr] = 1'b0;
    end
    if (wr_ok) begin
      mem_d[wr_addr]  = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    if (iss_ok) begin
      pend_d[iss_addr] = 1'b1;
    end
  end

  // Storage registers, zeroed asynchronously on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              busy;

      assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

      // Read mux: hardwired zero, then bypass (idle only), then the array.
      always_comb begin
        data = mem_q[addr];
        busy = pend_q[addr];
        if (ZERO_REG && (addr == '0)) begin
          data = '0;
          busy = 1'b0;
        end else if (BYPASS && idle && wr_en && (wr_addr == addr)) begin
          data = wr_data;
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = data;
      assign rd_busy[gi]                  = busy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default instance (zero reg, bypass)
// plus a second instance without zero reg and without bypass.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en, iss_en, clr_req;
  logic [4:0]  wr_addr, iss_addr, ra0, ra1;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic        clr_busy_a, clr_done_a, clr_busy_b, clr_done_b;

  int n_pass  = 0;
  int n_total = 0;

  assign rd_addr = {ra1, ra0};

  always #5 clk = ~clk;

  regfile_scoreboard u_dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .iss_en(iss_en), .iss_addr(iss_addr),
    .clr_req(clr_req), .clr_busy(clr_busy_a), .clr_done(clr_done_a)
  );

  regfile_scoreboard #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_nb (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .iss_en(iss_en), .iss_addr(iss_addr),
    .clr_req(clr_req), .clr_busy(clr_busy_b), .clr_done(clr_done_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %s observed=%0h ok", tag, obs);
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cycles, done_cnt, done_at, seen;
    logic [31:0] or_data;
    logic [3:0]  or_busy;

    reset_n = 1'b0; wr_en = 0; iss_en = 0; clr_req = 0;
    wr_addr = 0; iss_addr = 0; wr_data = 0; ra0 = 5'd5; ra1 = 5'd7;
    #2;
    chk("rst_rd_data_a", rd_data_a, 64'h0);
    chk("rst_rd_busy_a", rd_busy_a, 2'b00);
    chk("rst_clr_busy",  clr_busy_a, 1'b0);
    chk("rst_clr_done",  clr_done_a, 1'b0);
    chk("rst_rd_data_b", rd_data_b, 64'h0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // Write r5, read it back next cycle; port 1 reads r0.
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    tick;
    wr_en = 0; ra0 = 5; ra1 = 0; #1;
    chk("wr_r5", rd_data_a[31:0], 32'hDEADBEEF);
    chk("rd_r0", rd_data_a[63:32], 32'h0);

    // Write and issue r0 in one cycle.
    wr_en = 1; wr_addr = 0; wr_data = 32'h1234; iss_en = 1; iss_addr = 0;
    tick;
    wr_en = 0; iss_en = 0; ra0 = 0; #1;
    chk("zr_data",     rd_data_a[31:0], 32'h0);
    chk("zr_busy",     rd_busy_a[0], 1'b0);
    chk("nozr_data",   rd_data_b[31:0], 32'h1234);
    chk("nozr_busy",   rd_busy_b[0], 1'b1);

    // Same-cycle bypass of r7 on port 1.
    wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5; ra1 = 7; #1;
    chk("bypass_on",  rd_data_a[63:32], 32'hA5A5A5A5);
    chk("bypass_off", rd_data_b[63:32], 32'h0);
    tick;
    wr_en = 0; #1;
    chk("r7_after_a", rd_data_a[63:32], 32'hA5A5A5A5);
    chk("r7_after_b", rd_data_b[63:32], 32'hA5A5A5A5);

    // Scoreboard on r3.
    iss_en = 1; iss_addr = 3; ra0 = 3;
    tick;
    iss_en = 0; #1;
    chk("iss_r3_busy", rd_busy_a[0], 1'b1);
    wr_en = 1; wr_addr = 3; wr_data = 32'h33;
    tick;
    wr_en = 0; #1;
    chk("wr_r3_data", rd_data_a[31:0], 32'h33);
    chk("wr_r3_busy", rd_busy_a[0], 1'b0);
    wr_en = 1; wr_addr = 3; wr_data = 32'h44; iss_en = 1; iss_addr = 3;
    tick;
    wr_en = 0; iss_en = 0; #1;
    chk("wriss_r3_data", rd_data_a[31:0], 32'h44);
    chk("wriss_r3_busy", rd_busy_a[0], 1'b1);
    wr_en = 1; wr_addr = 6; wr_data = 32'h66; iss_en = 1; iss_addr = 4;
    tick;
    wr_en = 0; iss_en = 0; ra0 = 4; ra1 = 6; #1;
    chk("diff_busy",  rd_busy_a, 2'b01);
    chk("diff_r6",    rd_data_a[63:32], 32'h66);

    // Fill r1..r31 with data and pending bits.
    for (int i = 1; i < 32; i++) begin
      wr_en = 1; wr_addr = 5'(i); wr_data = 32'h100 + 32'(i);
      iss_en = 1; iss_addr = 5'(i);
      tick;
    end
    wr_en = 0; iss_en = 0; ra0 = 31; ra1 = 9; #1;
    chk("fill_r31_data", rd_data_a[31:0], 32'h11F);
    chk("fill_r31_busy", rd_busy_a[0], 1'b1);

    // Soft clear with a dropped write/issue and a re-request mid-clear.
    clr_req = 1;
    tick;
    clr_req = 0;
    busy_cycles = 0; done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        wr_en = 1; wr_addr = 9; wr_data = 32'hDEAD; iss_en = 1; iss_addr = 9;
      end
      if (k == 20) clr_req = 1;
      #1;
      if (!clr_busy_a) break;
      busy_cycles++;
      if (clr_done_a) begin
        done_cnt++;
        done_at = k;
      end
      if (k == 5) chk("clr_no_bypass", rd_data_a[63:32], 32'h109);
      tick;
      wr_en = 0; iss_en = 0; clr_req = 0;
    end
    chk("clr_busy_cycles", 64'(busy_cycles), 64'd33);
    chk("clr_done_count",  64'(done_cnt), 64'd1);
    chk("clr_done_cycle",  64'(done_at), 64'd33);
    chk("clr_busy_b_end",  clr_busy_b, 1'b0);
    or_data = '0; or_busy = '0;
    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a); ra1 = 5'(a); #1;
      or_data = or_data | rd_data_a[31:0] | rd_data_b[31:0];
      or_busy = or_busy | {rd_busy_a, rd_busy_b};
    end
    chk("clr_all_data", or_data, 32'h0);
    chk("clr_all_busy", or_busy, 4'h0);

    // Reset in the middle of a clear.
    tick;
    wr_en = 1; wr_addr = 20; wr_data = 32'h2020;
    tick;
    wr_en = 0; ra0 = 20; clr_req = 1;
    tick;
    clr_req = 0;
    repeat (9) tick;
    chk("mid_busy",      clr_busy_a, 1'b1);
    chk("mid_r20_pre",   rd_data_a[31:0], 32'h2020);
    reset_n = 1'b0; #1;
    chk("mid_rst_busy",  clr_busy_a, 1'b0);
    chk("mid_rst_done",  clr_done_a, 1'b0);
    chk("mid_rst_r20",   rd_data_a[31:0], 32'h0);
    seen = 0;
    repeat (3) begin
      tick;
      seen = seen | int'(clr_done_a) | int'(clr_busy_a);
    end
    reset_n = 1'b1;
    repeat (40) begin
      tick;
      seen = seen | int'(clr_done_a) | int'(clr_busy_a);
    end
    chk("mid_rst_no_done", 64'(seen), 64'd0);
    wr_en = 1; wr_addr = 20; wr_data = 32'h77;
    tick;
    wr_en = 0; #1;
    chk("post_rst_write", rd_data_a[31:0], 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
